// File: rtl/idex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU opcodes, default widths
// and the control bundle carried alongside each instruction.
package idex_operand_stage_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;

  // ALU opcode encodings, {ainv, binv, op[1:0]}
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Control bits that must be squashed on bubbles and flushes
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam int    CTRL_W    = $bits(ctrl_t);
  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/idex_operand_stage_if.sv
// ID-side instruction bundle in, EX-side registered bundle out.
interface idex_operand_stage_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               id_valid;
  logic [3:0]         id_alu_op;
  logic [RADDR_W-1:0] id_rs1;
  logic [RADDR_W-1:0] id_rs2;
  logic [XLEN-1:0]    id_rs1_data;
  logic [XLEN-1:0]    id_rs2_data;
  logic [XLEN-1:0]    id_imm;
  logic               id_use_imm;
  logic [RADDR_W-1:0] id_rd;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               id_mem_write;

  logic               ex_valid;
  logic [XLEN-1:0]    ex_a;
  logic [XLEN-1:0]    ex_b;
  logic [XLEN-1:0]    ex_store_data;
  logic [3:0]         ex_alu_op;
  logic [RADDR_W-1:0] ex_rd;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic               ex_mem_write;

  // Decode side: drives the ID bundle, observes the EX bundle
  modport master (
    output id_valid, id_alu_op, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_rd, id_reg_write, id_mem_read, id_mem_write,
    input  ex_valid, ex_a, ex_b, ex_store_data, ex_alu_op, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write
  );

  // Operand stage: consumes the ID bundle, produces the EX bundle
  modport slave (
    input  id_valid, id_alu_op, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
           id_imm, id_use_imm, id_rd, id_reg_write, id_mem_read, id_mem_write,
    output ex_valid, ex_a, ex_b, ex_store_data, ex_alu_op, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/idex_operand_stage_fwd_mux.sv
// Per-operand forwarding select: the EX-stage producer beats the MEM-stage
// producer, which beats the register file. Register 0 is never forwarded
// when it is hard-wired to zero.
module idex_fwd_mux #(
  parameter int XLEN        = 32,
  parameter int RADDR_W     = 5,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic [RADDR_W-1:0] src,
  input  logic [XLEN-1:0]    rf_data,
  input  logic               ex_fwd_en,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]    alu_result,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]    mem_result,
  output logic [XLEN-1:0]    fwd_data
);

  logic src_live;
  assign src_live = !ZERO_REG_EN || (src != '0);

  // Later assignments override earlier ones, so EX has the highest priority
  always_comb begin
    fwd_data = rf_data;
    if (src_live && mem_reg_write && (mem_rd == src)) fwd_data = mem_result;
    if (src_live && ex_fwd_en && (ex_rd == src))      fwd_data = alu_result;
  end

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: forwards operands from EX/MEM,
// inserts a single bubble on load-use, and honours hold and flush.
module idex_operand_stage
  import idex_operand_stage_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int RADDR_W     = RADDR_W_DEF,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  idex_operand_stage_if.slave  bus,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [RADDR_W-1:0]   mem_rd,
  input  logic                 mem_reg_write,
  input  logic [XLEN-1:0]      mem_result,
  input  logic                 hold,
  input  logic                 flush,
  output logic                 stall_id
);

  logic               ex_valid_reg;
  ctrl_t              ex_ctrl_reg;
  logic [XLEN-1:0]    ex_a_reg;
  logic [XLEN-1:0]    ex_b_reg;
  logic [XLEN-1:0]    ex_store_data_reg;
  logic [3:0]         ex_alu_op_reg;
  logic [RADDR_W-1:0] ex_rd_reg;

  logic            ex_fwd_en;
  logic            ex_rd_live;
  logic            luh;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  ctrl_t           id_ctrl;

  // A load in EX has no result yet, so it cannot forward from alu_result
  assign ex_fwd_en  = ex_valid_reg & ex_ctrl_reg.reg_write & ~ex_ctrl_reg.mem_read;
  assign ex_rd_live = !ZERO_REG_EN || (ex_rd_reg != '0);

  idex_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W), .ZERO_REG_EN(ZERO_REG_EN)) u_fwd_rs1 (
    .src(bus.id_rs1), .rf_data(bus.id_rs1_data),
    .ex_fwd_en(ex_fwd_en), .ex_rd(ex_rd_reg), .alu_result(alu_result),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .fwd_data(fwd_rs1)
  );

  idex_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W), .ZERO_REG_EN(ZERO_REG_EN)) u_fwd_rs2 (
    .src(bus.id_rs2), .rf_data(bus.id_rs2_data),
    .ex_fwd_en(ex_fwd_en), .ex_rd(ex_rd_reg), .alu_result(alu_result),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .fwd_data(fwd_rs2)
  );

  // rs2 only matters to the consumer when it is the B operand or store data
  assign luh = bus.id_valid & ex_valid_reg & ex_ctrl_reg.mem_read & ex_ctrl_reg.reg_write
             & ex_rd_live
             & ((ex_rd_reg == bus.id_rs1)
               | ((ex_rd_reg == bus.id_rs2) & (~bus.id_use_imm | bus.id_mem_write)));

  assign stall_id = (luh | hold) & ~flush;

  assign id_ctrl = bus.id_valid ? '{reg_write: bus.id_reg_write,
                                    mem_read:  bus.id_mem_read,
                                    mem_write: bus.id_mem_write}
                                : CTRL_NONE;

  // Stage register: flush > hold > load-use bubble > normal capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg      <= 1'b0;
      ex_ctrl_reg       <= CTRL_NONE;
      ex_a_reg          <= '0;
      ex_b_reg          <= '0;
      ex_store_data_reg <= '0;
      ex_alu_op_reg     <= '0;
      ex_rd_reg         <= '0;
    end else if (flush) begin
      ex_valid_reg <= 1'b0;
      ex_ctrl_reg  <= CTRL_NONE;
    end else if (hold) begin
      ex_valid_reg <= ex_valid_reg;
    end else if (luh) begin
      ex_valid_reg <= 1'b0;
      ex_ctrl_reg  <= CTRL_NONE;
    end else begin
      ex_valid_reg      <= bus.id_valid;
      ex_ctrl_reg       <= id_ctrl;
      ex_a_reg          <= fwd_rs1;
      ex_b_reg          <= bus.id_use_imm ? bus.id_imm : fwd_rs2;
      ex_store_data_reg <= fwd_rs2;
      ex_alu_op_reg     <= bus.id_alu_op;
      ex_rd_reg         <= bus.id_rd;
    end
  end

  assign bus.ex_valid      = ex_valid_reg;
  assign bus.ex_a          = ex_a_reg;
  assign bus.ex_b          = ex_b_reg;
  assign bus.ex_store_data = ex_store_data_reg;
  assign bus.ex_alu_op     = ex_alu_op_reg;
  assign bus.ex_rd         = ex_rd_reg;
  assign bus.ex_reg_write  = ex_ctrl_reg.reg_write;
  assign bus.ex_mem_read   = ex_ctrl_reg.mem_read;
  assign bus.ex_mem_write  = ex_ctrl_reg.mem_write;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Scoreboard bench for idex_operand_stage: the driver predicts the EX
// contents after each edge and queues them; the monitor pops and compares.
module tb_idex_operand_stage;
  import idex_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic        hold;
  logic        flush;
  logic        stall_id;

  idex_operand_stage_if bus ();

  idex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_result(alu_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .hold(hold), .flush(flush), .stall_id(stall_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          rw;
    bit          mr;
    bit          mw;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  op;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  exp_t m;                // what the EX stage should hold right now
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_txn  = 0;
  bit   mon_en = 1'b0;

  // Environment seen by the next issued instruction
  logic [31:0] env_alu  = '0;
  bit          env_mrw  = 1'b0;
  logic [4:0]  env_mrd  = '0;
  logic [31:0] env_mres = '0;
  bit          env_hold = 1'b0;
  bit          env_flush = 1'b0;

  // Newest in-flight writer of register s wins; r0 is never a real producer
  function automatic logic [31:0] ref_value(input logic [4:0] s, input logic [31:0] rf);
    if (s != 5'd0 && m.v && m.rw && !m.mr && m.rd == s) return env_alu;
    if (s != 5'd0 && env_mrw && env_mrd == s) return env_mres;
    return rf;
  endfunction

  // Monitor: one expected EX snapshot per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty at %0t: DUT ex_valid=%0b, no prediction queued", $time, bus.ex_valid);
        end else begin
          e = q.pop_front();
          n_txn++;
          if (bus.ex_valid !== e.v || bus.ex_reg_write !== e.rw || bus.ex_mem_read !== e.mr ||
              bus.ex_mem_write !== e.mw ||
              (e.v && (bus.ex_a !== e.a || bus.ex_b !== e.b || bus.ex_store_data !== e.sd ||
                       bus.ex_alu_op !== e.op || bus.ex_rd !== e.rd))) begin
            n_bad++;
            $display("FAIL ex_state txn=%0d actual v=%0b ctl=%0b%0b%0b a=%h b=%h sd=%h op=%b rd=%0d required v=%0b ctl=%0b%0b%0b a=%h b=%h sd=%h op=%b rd=%0d",
                     n_txn, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                     bus.ex_a, bus.ex_b, bus.ex_store_data, bus.ex_alu_op, bus.ex_rd,
                     e.v, e.rw, e.mr, e.mw, e.a, e.b, e.sd, e.op, e.rd);
          end else begin
            $display("txn %0d: v=%0b a=%h b=%h sd=%h op=%b rd=%0d ok", n_txn, e.v, e.a, e.b, e.sd, e.op, e.rd);
          end
        end
      end
    end
  end

  // Present one ID instruction for one cycle, check stall_id, queue the prediction
  task automatic issue(input bit v, input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input bit ui, input bit rw, input bit mr, input bit mw);
    bit   load_use;
    bit   exp_stall;
    exp_t nx;
    bus.id_valid = v;   bus.id_alu_op = op;   bus.id_rs1 = rs1;  bus.id_rs2 = rs2;
    bus.id_rd = rd;     bus.id_rs1_data = d1; bus.id_rs2_data = d2;
    bus.id_imm = imm;   bus.id_use_imm = ui;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    alu_result = env_alu; mem_reg_write = env_mrw; mem_rd = env_mrd; mem_result = env_mres;
    hold = env_hold; flush = env_flush;
    #1;
    // A load's data is not ready for a consumer directly behind it
    load_use  = v && m.v && m.mr && m.rw && m.rd != 5'd0 &&
                (m.rd == rs1 || (m.rd == rs2 && (!ui || mw)));
    exp_stall = (load_use || env_hold) && !env_flush;
    n_cmp++;
    if (stall_id !== exp_stall) begin
      n_bad++;
      $display("FAIL stall_id at %0t: actual %0b required %0b", $time, stall_id, exp_stall);
    end
    nx = m;
    if (env_flush || (!env_hold && load_use)) begin
      nx.v = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0;
    end else if (!env_hold) begin
      nx.v  = v;  nx.rw = v & rw;  nx.mr = v & mr;  nx.mw = v & mw;
      nx.a  = ref_value(rs1, d1);
      nx.sd = ref_value(rs2, d2);
      nx.b  = ui ? imm : nx.sd;
      nx.op = op; nx.rd = rd;
    end
    q.push_back(nx);
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    m = nx;
  endtask

  task automatic env_clear();
    env_alu = '0; env_mrw = 1'b0; env_mrd = '0; env_mres = '0; env_hold = 1'b0; env_flush = 1'b0;
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, stall_id} !== 5'b0 ||
        bus.ex_a !== '0 || bus.ex_b !== '0 || bus.ex_store_data !== '0 ||
        bus.ex_alu_op !== '0 || bus.ex_rd !== '0) begin
      n_bad++;
      $display("FAIL async_reset: actual v=%0b a=%h b=%h sd=%h op=%b rd=%0d stall=%0b required all zero",
               bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_store_data, bus.ex_alu_op, bus.ex_rd, stall_id);
    end
    m = '{default: '0};
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    m = '{default: '0};
    env_clear();
    bus.id_valid = 1'b0; bus.id_alu_op = '0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0; bus.id_use_imm = 1'b0;
    bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
    alu_result = '0; mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0; hold = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    pulse_reset();

    // ADD r3 = r1 + r2, then reset while it sits valid in EX
    issue(1, ALU_ADD, 1, 2, 3, 5, 7, 0, 0, 1, 0, 0);
    pulse_reset();
    issue(1, ALU_ADD, 1, 2, 3, 5, 7, 0, 0, 1, 0, 0);

    // EX forward beats MEM forward
    issue(1, ALU_ADD, 1, 2, 4, 1, 2, 0, 0, 1, 0, 0);
    env_alu = 32'h0000_00AA; env_mrw = 1; env_mrd = 4; env_mres = 32'h55;
    issue(1, ALU_SUB, 4, 1, 5, 9, 3, 0, 0, 1, 0, 0);
    env_clear();

    // Load-use: one bubble, then the load value arrives from MEM
    issue(1, ALU_ADD, 1, 0, 6, 100, 0, 4, 1, 1, 1, 0);
    issue(1, ALU_ADD, 6, 1, 7, 0, 3, 0, 0, 1, 0, 0);
    env_mrw = 1; env_mrd = 6; env_mres = 32'h1234;
    issue(1, ALU_ADD, 6, 1, 7, 0, 3, 0, 0, 1, 0, 0);
    env_clear();

    // Register 0 is neither forwarded nor a load-use source
    issue(1, ALU_ADD, 1, 2, 0, 1, 2, 0, 0, 1, 0, 0);
    env_alu = 32'hFFFF_FFFF; env_mrw = 1; env_mrd = 0; env_mres = 32'h0BAD;
    issue(1, ALU_OR, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0);
    env_clear();
    issue(1, ALU_ADD, 1, 0, 0, 4, 0, 0, 1, 1, 1, 0);
    issue(1, ALU_ADD, 0, 0, 9, 0, 0, 0, 0, 1, 0, 0);

    // Hold for three cycles, then flush together with hold
    issue(1, ALU_AND, 1, 2, 9, 32'hF0F0, 32'h0FF0, 0, 0, 1, 0, 0);
    env_hold = 1;
    repeat (3) issue(1, ALU_NOR, 2, 3, 10, 11, 22, 0, 0, 1, 0, 0);
    env_flush = 1;
    issue(1, ALU_NOR, 2, 3, 10, 11, 22, 0, 0, 1, 0, 0);
    env_clear();

    // Store with immediate B, store data forwarded from MEM
    env_mrw = 1; env_mrd = 10; env_mres = 32'hDEAD;
    issue(1, ALU_ADD, 1, 10, 0, 64, 1, 8, 1, 0, 0, 1);
    env_clear();

    // Hold overrides load-use; the bubble appears only once hold drops
    issue(1, ALU_ADD, 1, 0, 11, 4, 0, 0, 1, 1, 1, 0);
    env_hold = 1;
    repeat (2) issue(1, ALU_ADD, 11, 1, 12, 0, 3, 0, 0, 1, 0, 0);
    env_hold = 0;
    issue(1, ALU_ADD, 11, 1, 12, 0, 3, 0, 0, 1, 0, 0);
    issue(1, ALU_ADD, 11, 1, 12, 0, 3, 0, 0, 1, 0, 0);

    // Reset in the middle of a load-use stall
    issue(1, ALU_ADD, 1, 0, 13, 4, 0, 0, 1, 1, 1, 0);
    pulse_reset();
    issue(1, ALU_ADD, 13, 1, 14, 77, 3, 0, 0, 1, 0, 0);

    // Load then store of the loaded register (stalls) and ADDI (does not)
    issue(1, ALU_ADD, 1, 0, 14, 4, 0, 0, 1, 1, 1, 0);
    issue(1, ALU_ADD, 2, 14, 0, 8, 9, 12, 1, 0, 0, 1);
    issue(1, ALU_ADD, 2, 14, 0, 8, 9, 12, 1, 0, 0, 1);
    issue(1, ALU_ADD, 1, 0, 14, 4, 0, 0, 1, 1, 1, 0);
    issue(1, ALU_ADD, 2, 14, 15, 8, 9, 12, 1, 1, 0, 0);

    // Randomised traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ops [6];
      ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
      env_alu   = $urandom;
      env_mrw   = 1'($urandom_range(0, 1));
      env_mrd   = 5'($urandom_range(0, 3));
      env_mres  = $urandom;
      env_hold  = ($urandom_range(0, 99) < 15);
      env_flush = ($urandom_range(0, 99) < 8);
      issue(($urandom_range(0, 9) < 8), ops[$urandom_range(0, 5)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end
    env_clear();

    mon_en = 1'b0;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: actual %0d predictions left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
